// File: rtl/dds_phase_sweeper.sv
// Frequency-sweep sequencer for a DDS Compiler streaming phase-increment channel.
// Emits a staircase of phase increments from a start to a stop value, each held for a dwell time.
module dds_phase_sweeper #(
    parameter int PHASE_W = 16,
    parameter int DWELL_W = 24
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] cfg_start_inc,
    input  logic [PHASE_W-1:0] cfg_stop_inc,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_repeat,
    output logic               busy,
    output logic               done,
    output logic               m_axis_phase_tvalid,
    output logic [PHASE_W-1:0] m_axis_phase_tdata
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PHASE_W-1:0] r_start_inc;
    logic [PHASE_W-1:0] r_stop_inc;
    logic [PHASE_W-1:0] r_step;
    logic [DWELL_W-1:0] r_dwell_last;
    logic               r_repeat;
    logic               r_down;

    logic [PHASE_W-1:0] r_cur;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_done;

    logic [PHASE_W-1:0] w_cur_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_done_nxt;
    logic               w_load;

    logic [PHASE_W:0]   w_sum;
    logic [PHASE_W:0]   w_diff;
    logic               w_past_up;
    logic               w_past_down;
    logic [PHASE_W-1:0] w_step_val;
    logic               w_at_stop;
    logic               w_dwell_end;
    logic [DWELL_W-1:0] w_dwell_last_in;

    // The extra top bit of w_sum / w_diff catches overflow and underflow, so the
    // staircase never wraps and always lands exactly on the stop value.
    assign w_sum       = {1'b0, r_cur} + {1'b0, r_step};
    assign w_diff      = {1'b0, r_cur} - {1'b0, r_step};
    assign w_past_up   = (w_sum > {1'b0, r_stop_inc});
    assign w_past_down = w_diff[PHASE_W] || (w_diff[PHASE_W-1:0] < r_stop_inc);
    assign w_at_stop   = (r_cur == r_stop_inc);
    assign w_dwell_end = (r_cnt == r_dwell_last);

    always_comb begin
        w_step_val = w_sum[PHASE_W-1:0];
        if (r_down) begin
            w_step_val = w_past_down ? r_stop_inc : w_diff[PHASE_W-1:0];
        end else if (w_past_up) begin
            w_step_val = r_stop_inc;
        end
    end

    // A dwell of 0 behaves as 1, so the terminal count is stored as max(dwell,1)-1.
    assign w_dwell_last_in = (cfg_dwell == '0) ? '0 : (cfg_dwell - DWELL_W'(1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Abort outranks everything; start is only honoured from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_SWEEP;
                        w_load      = 1'b1;
                        w_cur_nxt   = cfg_start_inc;
                        w_cnt_nxt   = '0;
                    end
                end
                S_SWEEP: begin
                    if (w_dwell_end) begin
                        w_cnt_nxt = '0;
                        if (r_step == '0) begin
                            w_cur_nxt = r_cur;
                        end else if (w_at_stop) begin
                            if (r_repeat) begin
                                w_cur_nxt = r_start_inc;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_cur_nxt = w_step_val;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_start_inc  <= '0;
            r_stop_inc   <= '0;
            r_step       <= '0;
            r_dwell_last <= '0;
            r_repeat     <= 1'b0;
            r_down       <= 1'b0;
        end else if (w_load) begin
            r_start_inc  <= cfg_start_inc;
            r_stop_inc   <= cfg_stop_inc;
            r_step       <= cfg_step;
            r_dwell_last <= w_dwell_last_in;
            r_repeat     <= cfg_repeat;
            r_down       <= (cfg_start_inc > cfg_stop_inc);
        end
    end

    // The phase channel has no tready: tvalid stays high for the whole sweep and
    // the DDS consumes tdata on every cycle it is high.
    assign busy                = (r_state == S_SWEEP);
    assign m_axis_phase_tvalid = (r_state == S_SWEEP);
    assign m_axis_phase_tdata  = r_cur;
    assign done                = r_done;

endmodule

// File: tb/tb_dds_phase_sweeper.sv
// Testbench for dds_phase_sweeper: directed and random sweeps scored against a
// staircase reference model through an expected-value queue.
module tb_dds_phase_sweeper;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        abort;
    logic [15:0] cfg_start_inc;
    logic [15:0] cfg_stop_inc;
    logic [15:0] cfg_step;
    logic [23:0] cfg_dwell;
    logic        cfg_repeat;
    logic        busy;
    logic        done;
    logic        m_axis_phase_tvalid;
    logic [15:0] m_axis_phase_tdata;

    dds_phase_sweeper #(.PHASE_W(16), .DWELL_W(24)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .start               (start),
        .abort               (abort),
        .cfg_start_inc       (cfg_start_inc),
        .cfg_stop_inc        (cfg_stop_inc),
        .cfg_step            (cfg_step),
        .cfg_dwell           (cfg_dwell),
        .cfg_repeat          (cfg_repeat),
        .busy                (busy),
        .done                (done),
        .m_axis_phase_tvalid (m_axis_phase_tvalid),
        .m_axis_phase_tdata  (m_axis_phase_tdata)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic        exp_end_q[$];
    int          pass_q[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          n_done_seen = 0;
    int          n_done_exp = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One pass of the staircase: start, then step toward stop clamped at stop.
    function automatic void build_pass(input int s, input int e, input int st);
        int v;
        pass_q.delete();
        v = s;
        if (st == 0) begin
            pass_q.push_back(s);
            return;
        end
        forever begin
            pass_q.push_back(v);
            if (v == e) break;
            if (s <= e) v = (v + st > e) ? e : v + st;
            else        v = (v - st < e) ? e : v - st;
        end
    endfunction

    function automatic int eff_dwell(input int dw);
        return (dw == 0) ? 1 : dw;
    endfunction

    // limit == 0: one full pass ending in done; limit > 0: first limit cycles, then a cut-off.
    function automatic void push_expected(input int s, input int e, input int st, input int dw,
                                          input bit rep, input int limit);
        int n;
        int idx;
        build_pass(s, e, st);
        if (limit == 0) begin
            foreach (pass_q[i])
                for (int r = 0; r < eff_dwell(dw); r++) exp_q.push_back(16'(pass_q[i]));
            exp_end_q.push_back(1'b1);
            n_done_exp++;
        end else begin
            n = 0;
            idx = 0;
            while (n < limit) begin
                for (int r = 0; r < eff_dwell(dw) && n < limit; r++) begin
                    exp_q.push_back(16'(pass_q[idx]));
                    n++;
                end
                idx++;
                if (idx == pass_q.size()) begin
                    if (rep || st == 0) idx = 0;
                    else break;
                end
            end
            exp_end_q.push_back(1'b0);
        end
    endfunction

    // ---------------- monitor ----------------
    logic        prev_valid = 1'b0;
    logic [15:0] mon_exp;
    logic        mon_end;

    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            check("busy_eq_tvalid", int'(busy), int'(m_axis_phase_tvalid));
            if (m_axis_phase_tvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tvalid", int'(m_axis_phase_tvalid), 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("tdata", int'(m_axis_phase_tdata), int'(mon_exp));
                end
            end
            if (done === 1'b1) n_done_seen++;
            if (prev_valid && m_axis_phase_tvalid !== 1'b1) begin
                if (exp_end_q.size() == 0) begin
                    check("unexpected_end", int'(prev_valid), 0);
                end else begin
                    mon_end = exp_end_q.pop_front();
                    check("done_at_end", int'(done), int'(mon_end));
                end
            end else if (done === 1'b1) begin
                check("stray_done", int'(done), 0);
            end
            prev_valid = (m_axis_phase_tvalid === 1'b1);
        end
    end

    // ---------------- driver ----------------
    // stop_after > 0: abort (or reset) after that many output cycles.
    // poke_at > 0: mid-sweep, alter cfg_stop_inc and pulse start on that cycle.
    task automatic run_sweep(input int s, input int e, input int st, input int dw, input bit rep,
                             input int stop_after, input int poke_at, input bit use_reset);
        int budget;
        int k;
        cfg_start_inc = 16'(s);
        cfg_stop_inc  = 16'(e);
        cfg_step      = 16'(st);
        cfg_dwell     = 24'(dw);
        cfg_repeat    = rep;
        start         = 1'b1;
        push_expected(s, e, st, dw, rep, stop_after);
        @(negedge aclk);
        start = 1'b0;
        if (stop_after > 0) begin
            repeat (stop_after - 1) @(negedge aclk);
            if (use_reset) begin
                #2 aresetn = 1'b0;
                #1;
                check("rst_tvalid", int'(m_axis_phase_tvalid), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_tdata", int'(m_axis_phase_tdata), 0);
                check("rst_done", int'(done), 0);
                #4 aresetn = 1'b1;
                @(negedge aclk);
            end else begin
                abort = 1'b1;
                @(negedge aclk);
                abort = 1'b0;
            end
        end else begin
            build_pass(s, e, st);
            budget = pass_q.size() * eff_dwell(dw) + 16;
            k = 0;
            while (m_axis_phase_tvalid === 1'b1 && budget > 0) begin
                k++;
                start = (poke_at > 0 && k == poke_at);
                if (start) cfg_stop_inc = cfg_stop_inc ^ 16'h5a5a;
                @(negedge aclk);
                budget--;
            end
            start = 1'b0;
            check("sweep_finished", int'(m_axis_phase_tvalid), 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, e, st, dw, span, sa;
        bit rep;
        aresetn       = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        cfg_start_inc = '0;
        cfg_stop_inc  = '0;
        cfg_step      = '0;
        cfg_dwell     = '0;
        cfg_repeat    = 1'b0;
        #3;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_tvalid", int'(m_axis_phase_tvalid), 0);
        check("reset_tdata", int'(m_axis_phase_tdata), 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;

        run_sweep(819, 24576, 11878, 80, 1'b0, 0, 0, 1'b0);   // up, clamped endpoint
        run_sweep(24576, 819, 12288, 3, 1'b0, 0, 0, 1'b0);    // down, no underflow
        run_sweep(100, 300, 100, 0, 1'b1, 11, 0, 1'b0);       // repeat, dwell 0
        run_sweep(100, 300, 0, 0, 1'b1, 9, 0, 1'b0);          // single tone
        run_sweep(500, 500, 0, 2, 1'b0, 7, 0, 1'b0);          // single tone, start == stop
        run_sweep(777, 777, 5, 2, 1'b0, 0, 0, 1'b0);          // one-point sweep
        run_sweep(65000, 65535, 1000, 1, 1'b0, 0, 0, 1'b0);   // overflow clamps to stop
        run_sweep(500, 10, 1000, 1, 1'b0, 0, 0, 1'b0);        // underflow clamps to stop
        run_sweep(1000, 5000, 1000, 6, 1'b0, 8, 0, 1'b0);     // abort mid-dwell
        repeat (2) @(negedge aclk);

        start = 1'b1;                                          // start/abort collision
        abort = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        abort = 1'b0;
        check("collide_busy", int'(busy), 0);
        check("collide_tvalid", int'(m_axis_phase_tvalid), 0);
        @(negedge aclk);
        check("collide_idle", int'(busy), 0);

        run_sweep(2000, 10000, 2000, 4, 1'b0, 0, 6, 1'b0);    // config isolation
        run_sweep(3000, 100, 700, 2, 1'b1, 7, 0, 1'b1);       // async reset mid-sweep
        run_sweep(4000, 9000, 2500, 2, 1'b0, 0, 0, 1'b0);     // fresh sweep after reset

        for (int i = 0; i < 40; i++) begin
            s    = int'($urandom_range(65535, 0));
            e    = int'($urandom_range(65535, 0));
            span = (s > e) ? s - e : e - s;
            st   = int'($urandom_range(65535, span / 6 + 1));
            dw   = int'($urandom_range(4, 0));
            rep  = 1'($urandom_range(1, 0));
            if ($urandom_range(7, 0) == 0) st = 0;
            if (rep || st == 0) begin
                sa = int'($urandom_range(30, 1));
            end else if ($urandom_range(3, 0) == 0) begin
                sa = int'($urandom_range(eff_dwell(dw), 1));
            end else begin
                sa = 0;
            end
            run_sweep(s, e, st, dw, rep, sa, 0, 1'b0);
            repeat ($urandom_range(2, 0)) @(negedge aclk);
        end

        repeat (4) @(negedge aclk);
        check("exp_q_drained", exp_q.size(), 0);
        check("end_q_drained", exp_end_q.size(), 0);
        check("done_pulses", n_done_seen, n_done_exp);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
